// File: rtl/mux_layer3_rr.sv
// mux_layer3_rr: 4-lane round-robin serializer with single-entry per-lane buffers and a sticky overflow flag.
module mux_layer3_rr #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in00,
  input  logic [DATA_WIDTH-1:0] data_in01,
  input  logic [DATA_WIDTH-1:0] data_in10,
  input  logic [DATA_WIDTH-1:0] data_in11,
  input  logic [3:0]            valid_in,
  output logic [3:0]            ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  overflow
);
  logic [DATA_WIDTH-1:0] r_buf [4];
  logic [DATA_WIDTH-1:0] w_din [4];
  logic [3:0]            r_full;
  logic [1:0]            r_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_overflow;
  logic                  w_gnt_vld;
  logic [1:0]            w_gnt;
  assign w_din[0]  = data_in00;
  assign w_din[1]  = data_in01;
  assign w_din[2]  = data_in10;
  assign w_din[3]  = data_in11;
  assign ready_out = ~r_full;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign overflow  = r_overflow;
  // Scan from the farthest lane back to ptr so the lane closest to ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_full[r_ptr + 2'(k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = r_ptr + 2'(k);
      end
    end
  end
  // A full lane cannot accept, so accept and drain never hit the same lane at one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      r_full      <= 4'b0000;
      r_ptr       <= 2'd0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (valid_in[i] && !r_full[i]) begin
          r_buf[i]  <= w_din[i];
          r_full[i] <= 1'b1;
        end
      end
      if (w_gnt_vld) begin
        r_full[w_gnt] <= 1'b0;
        r_data_out    <= r_buf[w_gnt];
        r_ptr         <= w_gnt + 2'd1;
      end
      r_valid_out <= w_gnt_vld;
      if (|(valid_in & r_full)) r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_layer3_rr.sv
// tb_mux_layer3_rr: scoreboard bench for the round-robin serializer.
module tb_mux_layer3_rr;
  logic       clk;
  logic       reset;
  logic [3:0] data_in00, data_in01, data_in10, data_in11;
  logic [3:0] valid_in;
  logic [3:0] ready_out;
  logic [3:0] data_out;
  logic       valid_out;
  logic       overflow;
  int         n_cmp;
  int         n_bad;
  logic [3:0] sb_q [$];

  mux_layer3_rr #(.DATA_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .data_in00(data_in00), .data_in01(data_in01), .data_in10(data_in10), .data_in11(data_in11),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in  = 4'b0000;
    data_in00 = 4'h0;
    data_in01 = 4'h0;
    data_in10 = 4'h0;
    data_in11 = 4'h0;
  endtask

  task automatic rst_pulse();
    #1 reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (sb_q.size() > 0) chk("dout", {28'd0, data_out}, {28'd0, sb_q.pop_front()});
      else chk("spurious_valid", {31'd0, valid_out}, 32'd0);
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst_ready", {28'd0, ready_out}, 32'hF);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_dout", {28'd0, data_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("idle_valid", {31'd0, valid_out}, 32'd0);
    chk("idle_ready", {28'd0, ready_out}, 32'hF);

    valid_in = 4'b0001; data_in00 = 4'hA; sb_q.push_back(4'hA);
    cyc();
    idle_inputs();
    chk("t2_ready_k", {28'd0, ready_out}, 32'hE);
    chk("t2_valid_k", {31'd0, valid_out}, 32'd0);
    cyc();
    chk("t2_valid_k1", {31'd0, valid_out}, 32'd1);
    chk("t2_dout_k1", {28'd0, data_out}, 32'hA);
    chk("t2_ready_k1", {28'd0, ready_out}, 32'hF);
    cyc();
    chk("t2_valid_k2", {31'd0, valid_out}, 32'd0);
    chk("t2_hold_k2", {28'd0, data_out}, 32'hA);

    rst_pulse();
    valid_in = 4'b1111;
    data_in00 = 4'h1; data_in01 = 4'h2; data_in10 = 4'h3; data_in11 = 4'h4;
    for (int i = 1; i <= 4; i++) sb_q.push_back(4'(i));
    cyc();
    idle_inputs();
    chk("t3_ready_0", {28'd0, ready_out}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("t3_valid", {31'd0, valid_out}, 32'd1);
      chk("t3_ready", {28'd0, ready_out}, 32'((1 << i) - 1));
    end
    cyc();
    chk("t3_valid_end", {31'd0, valid_out}, 32'd0);

    valid_in = 4'b0010; data_in01 = 4'h5; sb_q.push_back(4'h5);
    cyc();
    idle_inputs();
    repeat (2) cyc();
    valid_in = 4'b0101; data_in00 = 4'h6; data_in10 = 4'h7;
    sb_q.push_back(4'h7); sb_q.push_back(4'h6);
    cyc();
    idle_inputs();
    repeat (3) cyc();
    valid_in = 4'b0011; data_in00 = 4'h8; data_in01 = 4'h9;
    sb_q.push_back(4'h9); sb_q.push_back(4'h8);
    cyc();
    idle_inputs();
    repeat (3) cyc();
    chk("t4_drained", sb_q.size(), 32'd0);

    valid_in = 4'b1000; data_in11 = 4'hB; sb_q.push_back(4'hB);
    cyc();
    chk("t5_ovf_pre", {31'd0, overflow}, 32'd0);
    data_in11 = 4'hC;
    cyc();
    idle_inputs();
    chk("t5_ovf", {31'd0, overflow}, 32'd1);
    chk("t5_dout", {28'd0, data_out}, 32'hB);
    repeat (3) cyc();
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("t5_ready", {28'd0, ready_out}, 32'hF);
    chk("t5_drained", sb_q.size(), 32'd0);

    valid_in = 4'b0111; data_in00 = 4'h1; data_in01 = 4'h2; data_in10 = 4'h3;
    cyc();
    idle_inputs();
    chk("t6_ready_loaded", {28'd0, ready_out}, 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_dout", {28'd0, data_out}, 32'd0);
    chk("t6_async_ovf", {31'd0, overflow}, 32'd0);
    chk("t6_async_ready", {28'd0, ready_out}, 32'hF);
    chk("t6_async_valid", {31'd0, valid_out}, 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_no_valid", {31'd0, valid_out}, 32'd0);
    end
    chk("t6_dout", {28'd0, data_out}, 32'd0);
    chk("t6_ready", {28'd0, ready_out}, 32'hF);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    chk("final_queue", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
